// File: rtl/elm_neuron_mac_pkg.sv
// elm_neuron_mac shared definitions:
// activation codes and saturation bound helpers.
package elm_neuron_mac_pkg;

  localparam int ACT_LINEAR = 0;
  localparam int ACT_RELU   = 1;

  // largest signed value of a w-bit field, low w bits valid
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // smallest signed value of a w-bit field, low w bits valid
  function automatic logic [63:0] sat_min(input int w);
    return ~64'd0 << (w - 1);
  endfunction

endpackage

// File: rtl/elm_sat_shift.sv
// elm_sat_shift: arithmetic right shift of a signed
// value, then saturating narrow to OUT_W bits.
module elm_sat_shift
  import elm_neuron_mac_pkg::*;
#(
  parameter int IN_W  = 33,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  logic [IN_W-1:0]     sh;
  logic [IN_W-OUT_W:0] hi;
  logic                ovf;

  // clamp when dropped upper bits are not pure sign
  always_comb begin
    sh   = IN_W'($signed(din) >>> SHIFT);
    hi   = sh[IN_W-1:OUT_W-1];
    ovf  = (|hi) && !(&hi);
    dout = sh[OUT_W-1:0];
    if (ovf) begin
      dout = sh[IN_W-1] ? OUT_W'(sat_min(OUT_W))
                        : OUT_W'(sat_max(OUT_W));
    end
  end

endmodule

// File: rtl/elm_neuron_mac.sv
// elm_neuron_mac: one hidden-layer neuron, serial
// multiply-accumulate, bias, activation.
module elm_neuron_mac
  import elm_neuron_mac_pkg::*;
#(
  parameter int layerNo      = 1,
  parameter int neuronNo     = 0,
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 12,
  parameter int actType      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [dataWidth-1:0]  in_data,
  input  logic                  in_valid,
  input  logic [dataWidth-1:0]  bias,
  output logic                  w_ren,
  output logic [addressWidth:0] w_raddr,
  input  logic [dataWidth-1:0]  w_rdata,
  output logic [dataWidth-1:0]  out_data,
  output logic                  out_valid
);

  localparam int AW = 2 * dataWidth;
  localparam int CW = addressWidth + 1;
  localparam int DW = dataWidth;
  localparam logic [CW-1:0] LAST = CW'(numWeight - 1);

  if (numWeight < 1 || numWeight > (1 << addressWidth) ||
      fracBits >= dataWidth || layerNo < 0 ||
      neuronNo < 0) begin : g_bad_param
    $error("elm_neuron_mac: bad parameter set");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] x_q, x_d;
  logic          v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
  logic [AW-1:0] prod_q, prod_d;
  logic          v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          v3_q, v3_d, l3_q, l3_d;
  logic [DW-1:0] out_q, out_d;
  logic          ov_q, ov_d;

  logic signed [AW-1:0] xe, we;
  logic [AW:0]   acc_sum, bias_ext, bias_sum;
  logic [AW-1:0] acc_sat, biased;
  logic [DW-1:0] narrowed;

  assign w_ren     = in_valid;
  assign w_raddr   = cnt_q;
  assign out_data  = out_q;
  assign out_valid = ov_q;

  // bias add saturated to accumulator width
  elm_sat_shift #(
    .IN_W (AW + 1),
    .OUT_W(AW),
    .SHIFT(0)
  ) u_bsat (
    .din (bias_sum),
    .dout(biased)
  );

  // drop fraction of the product format, clamp to output
  elm_sat_shift #(
    .IN_W (AW),
    .OUT_W(DW),
    .SHIFT(fracBits)
  ) u_osat (
    .din (biased),
    .dout(narrowed)
  );

  // next-state for counter, tag pipe, accumulator, output
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    v1_d = in_valid;
    x_d  = in_valid ? in_data : x_q;
    f1_d = in_valid ? (cnt_q == '0) : f1_q;
    l1_d = in_valid ? (cnt_q == LAST) : l1_q;

    xe     = {{DW{x_q[DW-1]}}, x_q};
    we     = {{DW{w_rdata[DW-1]}}, w_rdata};
    v2_d   = v1_q;
    prod_d = v1_q ? AW'(xe * we) : prod_q;
    f2_d   = v1_q ? f1_q : f2_q;
    l2_d   = v1_q ? l1_q : l2_q;

    acc_sum = {acc_q[AW-1], acc_q} +
              {prod_q[AW-1], prod_q};
    acc_sat = acc_sum[AW-1:0];
    if (acc_sum[AW] != acc_sum[AW-1]) begin
      acc_sat = acc_sum[AW] ? AW'(sat_min(AW))
                            : AW'(sat_max(AW));
    end
    v3_d  = v2_q;
    l3_d  = v2_q ? l2_q : l3_q;
    acc_d = acc_q;
    if (v2_q) acc_d = f2_q ? prod_q : acc_sat;

    bias_ext = {{(AW + 1 - DW){bias[DW-1]}}, bias};
    bias_sum = {acc_q[AW-1], acc_q} +
               (bias_ext << fracBits);
    out_d = out_q;
    ov_d  = 1'b0;
    if (v3_q && l3_q) begin
      ov_d  = 1'b1;
      out_d = narrowed;
      if (actType == ACT_RELU && narrowed[DW-1]) begin
        out_d = '0;
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      x_q    <= '0;
      v1_q   <= 1'b0;
      f1_q   <= 1'b0;
      l1_q   <= 1'b0;
      prod_q <= '0;
      v2_q   <= 1'b0;
      f2_q   <= 1'b0;
      l2_q   <= 1'b0;
      acc_q  <= '0;
      v3_q   <= 1'b0;
      l3_q   <= 1'b0;
      out_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      v1_q   <= v1_d;
      f1_q   <= f1_d;
      l1_q   <= l1_d;
      prod_q <= prod_d;
      v2_q   <= v2_d;
      f2_q   <= f2_d;
      l2_q   <= l2_d;
      acc_q  <= acc_d;
      v3_q   <= v3_d;
      l3_q   <= l3_d;
      out_q  <= out_d;
      ov_q   <= ov_d;
    end
  end

endmodule

// File: tb/tb_elm_neuron_mac.sv
// tb_elm_neuron_mac: directed vectors against a ReLU
// and a linear instance sharing the same stimulus.
module tb_elm_neuron_mac;

  localparam int DW = 16;
  localparam int AD = 10;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] bias = '0;

  logic          w_ren_r, w_ren_l;
  logic [AD:0]   w_raddr_r, w_raddr_l;
  logic [DW-1:0] w_rdata_r, w_rdata_l;
  logic [DW-1:0] out_data_r, out_data_l;
  logic          out_valid_r, out_valid_l;

  logic [DW-1:0] wmem [NW];

  int cyc = 0;
  int last_cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          c;
    logic [15:0] d;
  } pulse_t;

  pulse_t qr[$];
  pulse_t ql[$];

  typedef struct {
    logic [63:0] x;
    logic [63:0] w;
    logic [15:0] b;
    logic [15:0] er;
    logic [15:0] el;
  } vec_t;

  vec_t tbl[8];

  elm_neuron_mac #(
    .numWeight(NW), .actType(1)
  ) u_relu (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .bias(bias),
    .w_ren(w_ren_r), .w_raddr(w_raddr_r),
    .w_rdata(w_rdata_r),
    .out_data(out_data_r), .out_valid(out_valid_r)
  );

  elm_neuron_mac #(
    .numWeight(NW), .actType(0)
  ) u_lin (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .bias(bias),
    .w_ren(w_ren_l), .w_raddr(w_raddr_l),
    .w_rdata(w_rdata_l),
    .out_data(out_data_l), .out_valid(out_valid_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_ren_r) w_rdata_r <= wmem[w_raddr_r[1:0]];
    if (w_ren_l) w_rdata_l <= wmem[w_raddr_l[1:0]];
  end

  always @(negedge clk) begin
    if (out_valid_r) qr.push_back('{cyc, out_data_r});
    if (out_valid_l) ql.push_back('{cyc, out_data_l});
  end

  function automatic vec_t mkv(
    input logic [63:0] x, input logic [63:0] w,
    input logic [15:0] b, input logic [15:0] er,
    input logic [15:0] el);
    vec_t v;
    v.x = x; v.w = w; v.b = b; v.er = er; v.el = el;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] x,
                      input int ea, input string nm);
    @(negedge clk);
    in_data  = x;
    in_valid = 1'b1;
    last_cyc = cyc;
    #1;
    chk({nm, " w_ren"}, 32'(w_ren_r), 32'd1);
    chk({nm, " w_raddr"}, 32'(w_raddr_r), 32'(ea));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic chk_pulse(input string nm, input int ec,
                           input logic [15:0] er,
                           input logic [15:0] el);
    pulse_t p;
    p = '{-1, 16'hxxxx};
    if (qr.size() > 0) p = qr.pop_front();
    chk({nm, " relu lat"}, 32'(p.c), 32'(ec));
    chk({nm, " relu data"}, 32'(p.d), 32'(er));
    p = '{-1, 16'hxxxx};
    if (ql.size() > 0) p = ql.pop_front();
    chk({nm, " lin lat"}, 32'(p.c), 32'(ec));
    chk({nm, " lin data"}, 32'(p.d), 32'(el));
  endtask

  task automatic load_w(input logic [63:0] w);
    for (int i = 0; i < NW; i++) wmem[i] = w[16*i +: 16];
  endtask

  initial begin
    int la;
    int lb;
    tbl[0] = mkv(64'h1000_1000_1000_1000,
                 64'h1000_1000_1000_1000,
                 16'h0000, 16'h4000, 16'h4000);
    tbl[1] = mkv(64'h1000_1000_1000_1000,
                 64'hF000_F000_F000_F000,
                 16'h0800, 16'h0000, 16'hC800);
    tbl[2] = mkv(64'h7FFF_7FFF_7FFF_7FFF,
                 64'h7FFF_7FFF_7FFF_7FFF,
                 16'h0000, 16'h7FFF, 16'h7FFF);
    tbl[3] = mkv(64'h7FFF_7FFF_7FFF_7FFF,
                 64'h8000_8000_8000_8000,
                 16'h0000, 16'h0000, 16'h8000);
    tbl[4] = mkv(64'h0800_F000_2000_1000,
                 64'h1000_1000_1000_1000,
                 16'h0000, 16'h2800, 16'h2800);
    tbl[5] = mkv(64'h0000_0000_0000_0001,
                 64'h0000_0000_0000_FFFF,
                 16'h0000, 16'h0000, 16'hFFFF);
    tbl[6] = mkv(64'h0, 64'h0,
                 16'h8000, 16'h0000, 16'h8000);
    tbl[7] = mkv(64'h0, 64'h0,
                 16'h1234, 16'h1234, 16'h1234);

    load_w(64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst w_ren", 32'(w_ren_r), 32'd0);
    chk("rst w_raddr", 32'(w_raddr_r), 32'd0);
    chk("rst out_data", 32'(out_data_r), 32'd0);
    chk("rst out_valid", 32'(out_valid_r), 32'd0);
    chk("rst lin out_data", 32'(out_data_l), 32'd0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      idle(1);
      load_w(tbl[k].w);
      bias = tbl[k].b;
      for (int i = 0; i < NW; i++) begin
        send(tbl[k].x[16*i +: 16], i,
             $sformatf("v%0d s%0d", k, i));
      end
      la = last_cyc;
      idle(8);
      chk_pulse($sformatf("v%0d", k), la + 4,
                tbl[k].er, tbl[k].el);
      chk($sformatf("v%0d extra", k),
          32'(qr.size() + ql.size()), 32'd0);
      chk($sformatf("v%0d hold", k),
          32'(out_data_l), 32'(tbl[k].el));
    end

    load_w(64'h1000_1000_1000_1000);
    bias = '0;
    for (int i = 0; i < 2 * NW; i++) begin
      send(i < NW ? 16'h1000 : 16'h0800, i % NW, "b2b");
      if (i == NW - 1) la = last_cyc;
    end
    lb = last_cyc;
    idle(8);
    chk("b2b gap", 32'(lb - la), 32'd4);
    chk_pulse("b2b A", la + 4, 16'h4000, 16'h4000);
    chk_pulse("b2b B", lb + 4, 16'h2000, 16'h2000);

    send(16'h1000, 0, "rst s0");
    send(16'h1000, 1, "rst s1");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(8);
    chk("rst no pulse", 32'(qr.size() + ql.size()), 32'd0);
    for (int i = 0; i < NW; i++) send(16'h1000, i, "post");
    la = last_cyc;
    idle(8);
    chk_pulse("post", la + 4, 16'h4000, 16'h4000);

    for (int i = 0; i < 2 * NW; i++) begin
      idle($urandom_range(0, 3));
      send(i < NW ? 16'h1000 : 16'h0C00, i % NW, "gap");
      if (i == NW - 1) la = last_cyc;
    end
    lb = last_cyc;
    idle(8);
    chk_pulse("gap A", la + 4, 16'h4000, 16'h4000);
    chk_pulse("gap B", lb + 4, 16'h3000, 16'h3000);
    chk("gap extra", 32'(qr.size() + ql.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
